// File: rtl/regfile_ctrl_unit.sv
// 32x32 register file with combinational reads plus single-cycle instruction decode.
// Optional macro RF_BYPASS_EN forwards a same-cycle write to the read ports.
module regfile_ctrl_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [31:0] write_data,
    output logic [5:0]  function_code,
    output logic [4:0]  shamt,
    output logic [20:0] constant,
    output logic [31:0] data1,
    output logic [31:0] data2,
    output logic        ALUSrc,
    output logic        ALUtoReg,
    output logic        reg_write,
    output logic        illegal
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_IMM   = 6'h3F;
    localparam logic [5:0] OP_LOAD  = 6'h23;

    logic [5:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rf_reg [32];
    logic        funct_legal;
    logic [31:0] rd1_raw;
    logic [31:0] rd2_raw;

    assign opcode        = instruction[31:26];
    assign rd            = instruction[25:21];
    assign rs1           = instruction[20:16];
    assign rs2           = instruction[15:11];
    assign shamt         = instruction[10:6];
    assign function_code = instruction[5:0];
    assign constant      = instruction[20:0];

    always_comb begin
        case (function_code)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02: funct_legal = 1'b1;
            default:                                         funct_legal = 1'b0;
        endcase
    end

    // Unsupported encodings fall through to the default: no write, illegal flagged.
    always_comb begin
        ALUSrc    = 1'b0;
        ALUtoReg  = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                if (funct_legal) begin
                    ALUtoReg  = 1'b1;
                    reg_write = 1'b1;
                    illegal   = 1'b0;
                end
            end
            OP_IMM: begin
                ALUSrc    = 1'b1;
                ALUtoReg  = 1'b1;
                reg_write = 1'b1;
                illegal   = 1'b0;
            end
            OP_LOAD: begin
                ALUSrc    = 1'b1;
                reg_write = 1'b1;
                illegal   = 1'b0;
            end
            default: ;
        endcase
    end

    // Entry 0 is never written, so it holds its reset value; reads also force it to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_reg[i] <= '0;
            end
        end else if (reg_write && (rd != 5'd0)) begin
            rf_reg[rd] <= write_data;
        end
    end

    assign rd1_raw = (rs1 == 5'd0) ? 32'h0 : rf_reg[rs1];
    assign rd2_raw = (rs2 == 5'd0) ? 32'h0 : rf_reg[rs2];

`ifdef RF_BYPASS_EN
    logic write_live;
    assign write_live = reg_write && (rd != 5'd0) && !rst;
    assign data1 = (write_live && (rs1 == rd)) ? write_data : rd1_raw;
    assign data2 = (write_live && (rs2 == rd)) ? write_data : rd2_raw;
`else
    assign data1 = rd1_raw;
    assign data2 = rd2_raw;
`endif

endmodule

// File: tb/tb_regfile_ctrl_unit.sv
// Directed bench for regfile_ctrl_unit: decode, read/write, rd=0 discard, reset priority.
// Honours RF_BYPASS_EN to pick the expected same-cycle read value.
module tb_regfile_ctrl_unit;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] write_data;
    logic [5:0]  function_code;
    logic [4:0]  shamt;
    logic [20:0] constant;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        ALUSrc;
    logic        ALUtoReg;
    logic        reg_write;
    logic        illegal;

    int tests;
    int failed;

    regfile_ctrl_unit dut (
        .clk           (clk),
        .rst           (rst),
        .instruction   (instruction),
        .write_data    (write_data),
        .function_code (function_code),
        .shamt         (shamt),
        .constant      (constant),
        .data1         (data1),
        .data2         (data2),
        .ALUSrc        (ALUSrc),
        .ALUtoReg      (ALUtoReg),
        .reg_write     (reg_write),
        .illegal       (illegal)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [4:0] sh, input logic [5:0] fn);
        return {op, rd, rs1, rs2, sh, fn};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic read_chk(input int r, input logic [31:0] exp, input string tag);
        instruction = mk(6'h00, 5'd0, 5'(r), 5'(r), 5'd0, 6'h20);
        write_data  = 32'h0;
        #1;
        check($sformatf("%s_r%0d_d1", tag, r), data1, exp);
        check($sformatf("%s_r%0d_d2", tag, r), data2, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0]  legal_functs [7];
    logic [31:0] exp_same;

    initial begin
        tests = 0;
        failed = 0;
        legal_functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
        rst = 1'b1;
        instruction = 32'h0;
        write_data = 32'h0;
        tick();
        tick();
        rst = 1'b0;

        for (int r = 0; r < 32; r++) read_chk(r, 32'h0, "reset");

        // R-type add with rd=0
        instruction = 32'h00011020;
        write_data  = 32'hdeadbeef;
        #1;
        check("r_data1", data1, 32'h0);
        check("r_data2", data2, 32'h0);
        check("r_funct", 32'(function_code), 32'h20);
        check("r_alusrc", 32'(ALUSrc), 32'h0);
        check("r_alutoreg", 32'(ALUtoReg), 32'h1);
        check("r_regwrite", 32'(reg_write), 32'h1);
        check("r_illegal", 32'(illegal), 32'h0);
        tick();
        read_chk(0, 32'h0, "rd0_after_edge");

        // Distinct pattern in every register
        for (int r = 1; r < 32; r++) begin
            instruction = mk(6'h00, 5'(r), 5'd0, 5'd0, 5'd0, 6'h20);
            write_data  = 32'hA5000000 | 32'(r);
            tick();
        end

        instruction = 32'hfc00001a;
        write_data  = 32'h50607080;
        #1;
        check("imm_constant", 32'(constant), 32'h00001a);
        check("imm_funct", 32'(function_code), 32'h1a);
        check("imm_alusrc", 32'(ALUSrc), 32'h1);
        check("imm_alutoreg", 32'(ALUtoReg), 32'h1);
        check("imm_regwrite", 32'(reg_write), 32'h1);
        check("imm_illegal", 32'(illegal), 32'h0);
        tick();
        for (int r = 1; r < 32; r++) read_chk(r, 32'hA5000000 | 32'(r), "imm_rd0");

        instruction = mk(6'h23, 5'd0, 5'd1, 5'd2, 5'd0, 6'h3F);
        #1;
        check("ld_alusrc", 32'(ALUSrc), 32'h1);
        check("ld_alutoreg", 32'(ALUtoReg), 32'h0);
        check("ld_regwrite", 32'(reg_write), 32'h1);
        check("ld_illegal", 32'(illegal), 32'h0);

        instruction = mk(6'h00, 5'd0, 5'd0, 5'd0, 5'h13, 6'h00);
        #1;
        check("shamt", 32'(shamt), 32'h13);

        instruction = 32'h00A00020;
        write_data  = 32'hfff34ff7;
        tick();
        instruction = 32'h00050020;
        write_data  = 32'h0;
        #1;
        check("wr5_data1", data1, 32'hfff34ff7);
        check("wr5_data2", data2, 32'h0);

        foreach (legal_functs[i]) begin
            instruction = mk(6'h00, 5'd0, 5'd0, 5'd0, 5'd0, legal_functs[i]);
            #1;
            check($sformatf("funct%02h_illegal", legal_functs[i]), 32'(illegal), 32'h0);
            check($sformatf("funct%02h_regwrite", legal_functs[i]), 32'(reg_write), 32'h1);
        end

        instruction = mk(6'h3E, 5'd5, 5'd0, 5'd0, 5'd0, 6'h20);
        write_data  = 32'h12345678;
        #1;
        check("op3e_illegal", 32'(illegal), 32'h1);
        check("op3e_regwrite", 32'(reg_write), 32'h0);
        check("op3e_alusrc", 32'(ALUSrc), 32'h0);
        check("op3e_alutoreg", 32'(ALUtoReg), 32'h0);
        tick();
        read_chk(5, 32'hfff34ff7, "op3e_keep");

        instruction = mk(6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h3F);
        #1;
        check("f3f_illegal", 32'(illegal), 32'h1);
        check("f3f_regwrite", 32'(reg_write), 32'h0);
        instruction = mk(6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h21);
        #1;
        check("f21_illegal", 32'(illegal), 32'h1);

`ifdef RF_BYPASS_EN
        exp_same = 32'h0000abcd;
`else
        exp_same = 32'hfff34ff7;
`endif
        instruction = mk(6'h00, 5'd5, 5'd5, 5'd5, 5'd0, 6'h20);
        write_data  = 32'h0000abcd;
        #1;
        check("same_data1", data1, exp_same);
        check("same_data2", data2, exp_same);
        tick();
        read_chk(5, 32'h0000abcd, "same_after");

        instruction = mk(6'h00, 5'd7, 5'd0, 5'd0, 5'd0, 6'h20);
        write_data  = 32'h77777777;
        rst = 1'b1;
        #1;
        check("rst_regwrite", 32'(reg_write), 32'h1);
        check("rst_illegal", 32'(illegal), 32'h0);
        tick();
        rst = 1'b0;
        for (int r = 0; r < 32; r++) read_chk(r, 32'h0, "rst_wr");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
